// File: rtl/i2c_byte_writer.sv
// rtl/i2c_byte_writer.sv - single 3-byte I2C write master (addr, reg, payload) with quarter-bit tick divider
// Optional feature macro: I2C_CLOCK_STRETCH_EN (honour slave clock stretching on SCL readback).
module i2c_byte_writer #(
  parameter int CLK_DIV = 63
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  slave_address,
  input  logic [15:0] register_data,
  input  logic        i2c_serial_data_in,
  input  logic        i2c_serial_clock_in,
  output logic        i2c_serial_data_oe,
  output logic        i2c_serial_clock,
  output logic        busy,
  output logic        done,
  output logic        ack_error
);

  localparam logic [9:0] TC = 10'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BYTE,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t      state;
  logic [9:0]  tick_cnt;
  logic [1:0]  phase;
  logic [1:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic [23:0] shift;
  logic        nack;
  logic        running;
  logic        accept;
  logic        stall;
  logic        tick;

  assign running = (state == S_START) || (state == S_BYTE) ||
                   (state == S_ACK)   || (state == S_STOP);
  // The done cycle is already IDLE, so a start coinciding with done is refused here.
  assign accept  = (state == S_IDLE) && start && !done;
  assign tick    = running && !stall && (tick_cnt == TC);

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave holding SCL low while we release it freezes the phase timer at zero.
  assign stall = i2c_serial_clock && !i2c_serial_clock_in;
`else
  logic unused_clock_in;
  assign unused_clock_in = i2c_serial_clock_in;
  assign stall = 1'b0;
`endif

  always_ff @(posedge clock_25) begin
    if (reset || accept || !running || stall || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state              <= S_IDLE;
      phase              <= '0;
      byte_idx           <= '0;
      bit_idx            <= '0;
      shift              <= '0;
      nack               <= 1'b0;
      i2c_serial_clock   <= 1'b1;
      i2c_serial_data_oe <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      ack_error          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shift              <= {slave_address, register_data};
            ack_error          <= 1'b0;
            nack               <= 1'b0;
            busy               <= 1'b1;
            phase              <= '0;
            i2c_serial_clock   <= 1'b1;
            i2c_serial_data_oe <= 1'b0;
            state              <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            phase <= phase + 1'b1;
            case (phase)
              2'd0: i2c_serial_data_oe <= 1'b1;
              2'd2: i2c_serial_clock   <= 1'b0;
              2'd3: begin
                state              <= S_BYTE;
                byte_idx           <= '0;
                bit_idx            <= 3'd7;
                i2c_serial_data_oe <= ~shift[23];
              end
              default: ;
            endcase
          end
        end

        S_BYTE: begin
          if (tick) begin
            phase <= phase + 1'b1;
            case (phase)
              2'd0: i2c_serial_clock <= 1'b1;
              2'd2: i2c_serial_clock <= 1'b0;
              2'd3: begin
                // The next bit to present is shift[22], which becomes the MSB after this shift.
                shift <= {shift[22:0], 1'b0};
                if (bit_idx == 3'd0) begin
                  state              <= S_ACK;
                  i2c_serial_data_oe <= 1'b0;
                end else begin
                  bit_idx            <= bit_idx - 1'b1;
                  i2c_serial_data_oe <= ~shift[22];
                end
              end
              default: ;
            endcase
          end
        end

        S_ACK: begin
          if (tick) begin
            phase <= phase + 1'b1;
            case (phase)
              2'd0: i2c_serial_clock <= 1'b1;
              2'd2: begin
                i2c_serial_clock <= 1'b0;
                nack             <= i2c_serial_data_in;
                if (i2c_serial_data_in) begin
                  ack_error <= 1'b1;
                end
              end
              2'd3: begin
                if (nack || (byte_idx == 2'd2)) begin
                  state              <= S_STOP;
                  i2c_serial_data_oe <= 1'b1;
                end else begin
                  state              <= S_BYTE;
                  byte_idx           <= byte_idx + 1'b1;
                  bit_idx            <= 3'd7;
                  i2c_serial_data_oe <= ~shift[23];
                end
              end
              default: ;
            endcase
          end
        end

        S_STOP: begin
          if (tick) begin
            phase <= phase + 1'b1;
            case (phase)
              2'd0: i2c_serial_clock   <= 1'b1;
              2'd2: i2c_serial_data_oe <= 1'b0;
              2'd3: state              <= S_DONE;
              default: ;
            endcase
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
